// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and next-PC selection feeding Instruction_Memory.
// A BOOT/RUN/HALTED state machine gates instruction fetch after reset and
// freezes the PC on a halt instruction.
// Optional feature: define PC_BOUND_CHECK_EN to halt with a sticky AddrErr when
// the next PC would fall outside the MEM_BYTES instruction memory. Without the
// macro the PC wraps modulo 2^32 and AddrErr is constant 0.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter int unsigned MEM_BYTES  = 256
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        PCWre,
   input  logic [1:0]  PCSrc,
   input  logic [15:0] Immediate,
   input  logic [25:0] JumpAddr,
   input  logic        Halt,
   output logic [31:0] InsAddr,
   output logic        InsMemRW,
   output logic [31:0] PC4,
   output logic        Running,
   output logic        AddrErr
);

   localparam int unsigned AddrW = 32;
   localparam int unsigned ImmW  = 16;
   localparam int unsigned JmpW  = 26;

`ifdef PC_BOUND_CHECK_EN
   localparam bit BoundCheckEn = 1'b1;
`else
   localparam bit BoundCheckEn = 1'b0;
`endif

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [AddrW-1:0]   pc_q, pc_d;
   logic               insmemrw_q, insmemrw_d;
   logic               running_q, running_d;
   logic               addr_err_q, addr_err_d;

   logic [AddrW-1:0]   pc_seq_c;
   logic [AddrW-1:0]   br_off_c;
   logic [AddrW-1:0]   pc_target_c;
   logic               oob_c;

   // Candidate next PC from the PCSrc selector; all sums wrap modulo 2^32.
   always_comb begin
      pc_seq_c    = pc_q + AddrW'(4);
      br_off_c    = {{(AddrW-ImmW-2){Immediate[ImmW-1]}}, Immediate, 2'b00};
      pc_target_c = pc_q;
      unique case (PCSrc)
         2'b00:   pc_target_c = pc_seq_c;
         2'b01:   pc_target_c = pc_seq_c + br_off_c;
         2'b10:   pc_target_c = {pc_seq_c[AddrW-1:AddrW-4], JumpAddr[JmpW-1:0], 2'b00};
         default: pc_target_c = pc_q;
      endcase
   end

   // Range check on the candidate PC; folds to 0 when the feature is disabled.
   always_comb begin
      oob_c = BoundCheckEn && (pc_target_c >= AddrW'(MEM_BYTES));
   end

   // Next-state, next-PC and registered-output decode.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      addr_err_d = addr_err_q;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (Halt) begin
               state_d = HALTED;
            end else if (PCWre) begin
               if (oob_c) begin
                  state_d    = HALTED;
                  addr_err_d = 1'b1;
               end else begin
                  pc_d = pc_target_c;
               end
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = BOOT;
         end
      endcase
      insmemrw_d = (state_d != BOOT);
      running_d  = (state_d == RUN);
   end

   // State and PC registers with synchronous active-high reset.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q    <= BOOT;
         pc_q       <= RESET_ADDR;
         insmemrw_q <= 1'b0;
         running_q  <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         insmemrw_q <= insmemrw_d;
         running_q  <= running_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign InsAddr  = pc_q;
   assign PC4      = pc_q + AddrW'(4);
   assign InsMemRW = insmemrw_q;
   assign Running  = running_q;
   assign AddrErr  = addr_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed vectors, a behavioural reference model
// compared every cycle, and literal expectations at key points.
module tb_pc_fetch_unit;

   localparam logic [31:0] RST_ADDR = 32'h0000_0000;
   localparam int unsigned MEMB     = 256;

   logic        CLK;
   logic        Reset;
   logic        PCWre;
   logic [1:0]  PCSrc;
   logic [15:0] Immediate;
   logic [25:0] JumpAddr;
   logic        Halt;
   logic [31:0] InsAddr;
   logic        InsMemRW;
   logic [31:0] PC4;
   logic        Running;
   logic        AddrErr;

   int n_checks = 0;
   int n_fail   = 0;

   pc_fetch_unit #(.RESET_ADDR(RST_ADDR), .MEM_BYTES(MEMB)) dut (
      .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc),
      .Immediate(Immediate), .JumpAddr(JumpAddr), .Halt(Halt),
      .InsAddr(InsAddr), .InsMemRW(InsMemRW), .PC4(PC4),
      .Running(Running), .AddrErr(AddrErr)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

`ifdef PC_BOUND_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   // Reference model: phase 0 = waiting one cycle after reset, 1 = fetching, 2 = stopped.
   bit          m_valid = 1'b0;
   int          m_phase = 0;
   logic [31:0] m_pc    = '0;
   bit          m_err   = 1'b0;

   always @(posedge CLK) begin
      longint t;
      if (Reset) begin
         m_valid = 1'b1;
         m_phase = 0;
         m_pc    = RST_ADDR;
         m_err   = 1'b0;
      end else if (m_phase == 0) begin
         m_phase = 1;
      end else if (m_phase == 1) begin
         if (Halt) begin
            m_phase = 2;
         end else if (PCWre) begin
            case (PCSrc)
               2'b00:   t = longint'(m_pc) + 4;
               2'b01:   t = longint'(m_pc) + 4 + 4 * longint'($signed(Immediate));
               2'b10:   t = longint'(((longint'(m_pc) + 4) & 64'hF000_0000))
                            + 4 * longint'(JumpAddr);
               default: t = longint'(m_pc);
            endcase
            t = t & 64'hFFFF_FFFF;
            if (CHK && t >= longint'(MEMB)) begin
               m_phase = 2;
               m_err   = 1'b1;
            end else begin
               m_pc = 32'(t);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT outputs against the model one time unit after each edge.
   always @(posedge CLK) begin
      #1;
      if (m_valid) begin
         check("model_InsAddr",  InsAddr,  m_pc);
         check("model_PC4",      PC4,      m_pc + 32'd4);
         check("model_InsMemRW", 32'(InsMemRW), 32'(m_phase != 0));
         check("model_Running",  32'(Running),  32'(m_phase == 1));
         check("model_AddrErr",  32'(AddrErr),  32'(m_err));
         check("addr_aligned",   32'(InsAddr[1:0]), 32'd0);
      end
   end

   task automatic cyc(input logic rst, input logic we, input logic [1:0] src,
                      input logic [15:0] imm, input logic [25:0] ja, input logic hlt);
      Reset = rst; PCWre = we; PCSrc = src; Immediate = imm; JumpAddr = ja; Halt = hlt;
      @(posedge CLK);
      #2;
   endtask

   task automatic lit(input string name, input logic [31:0] addr, input logic rw,
                      input logic run, input logic err);
      check({name, "_InsAddr"},  InsAddr,  addr);
      check({name, "_InsMemRW"}, 32'(InsMemRW), 32'(rw));
      check({name, "_Running"},  32'(Running),  32'(run));
      check({name, "_AddrErr"},  32'(AddrErr),  32'(err));
   endtask

   initial begin
      // Reset held two cycles.
      cyc(1, 1, 2'b00, 16'h0, 26'h0, 0); lit("rst1", 32'h0, 0, 0, 0);
      cyc(1, 1, 2'b00, 16'h0, 26'h0, 0); lit("rst2", 32'h0, 0, 0, 0);
      // BOOT edge: PC unchanged, fetch enabled.
      cyc(0, 1, 2'b00, 16'h0, 26'h0, 0); lit("boot", 32'h0, 1, 1, 0);
      // Sequential fetch.
      cyc(0, 1, 2'b00, 16'h0, 26'h0, 0); lit("seq4", 32'h4, 1, 1, 0);
      check("seq4_PC4", PC4, 32'h8);
      cyc(0, 1, 2'b00, 16'h0, 26'h0, 0); lit("seq8", 32'h8, 1, 1, 0);
      // Backward then forward branch.
      cyc(0, 1, 2'b01, 16'hFFFE, 26'h0, 0); lit("br_back", 32'h4, 1, 1, 0);
      cyc(0, 1, 2'b01, 16'h0003, 26'h0, 0); lit("br_fwd", 32'h14, 1, 1, 0);
      // Jump.
      cyc(0, 1, 2'b10, 16'h0, 26'h10, 0); lit("jump", 32'h40, 1, 1, 0);
      // Stall two cycles, then explicit hold select.
      cyc(0, 0, 2'b00, 16'h0, 26'h0, 0); lit("stall1", 32'h40, 1, 1, 0);
      cyc(0, 0, 2'b01, 16'h7, 26'h0, 0); lit("stall2", 32'h40, 1, 1, 0);
      cyc(0, 1, 2'b11, 16'h0, 26'h0, 0); lit("hold", 32'h40, 1, 1, 0);
      // Halt beats a pending jump.
      cyc(0, 1, 2'b10, 16'h0, 26'h3F, 1); lit("halt", 32'h40, 1, 0, 0);
      cyc(0, 1, 2'b00, 16'h0, 26'h0, 0); lit("halted1", 32'h40, 1, 0, 0);
      cyc(0, 1, 2'b01, 16'h10, 26'h0, 0); lit("halted2", 32'h40, 1, 0, 0);
      // Reset out of HALTED.
      cyc(1, 1, 2'b00, 16'h0, 26'h0, 0); lit("rst_halt", 32'h0, 0, 0, 0);
      cyc(0, 1, 2'b10, 16'h0, 26'h3F, 0); lit("boot2", 32'h0, 1, 1, 0);
      // Jump to the last word of memory, then step past it.
      cyc(0, 1, 2'b10, 16'h0, 26'h3F, 0); lit("to252", 32'hFC, 1, 1, 0);
      cyc(0, 1, 2'b00, 16'h0, 26'h0, 0);
`ifdef PC_BOUND_CHECK_EN
      lit("oob", 32'hFC, 1, 0, 1);
      cyc(0, 1, 2'b00, 16'h0, 26'h0, 0); lit("oob_sticky", 32'hFC, 1, 0, 1);
      cyc(1, 1, 2'b00, 16'h0, 26'h0, 0); lit("oob_rst", 32'h0, 0, 0, 0);
      cyc(0, 1, 2'b00, 16'h0, 26'h0, 0); lit("boot3", 32'h0, 1, 1, 0);
`else
      lit("past256", 32'h100, 1, 1, 0);
      // Wrap-around arithmetic.
      cyc(1, 1, 2'b00, 16'h0, 26'h0, 0);
      cyc(0, 1, 2'b00, 16'h0, 26'h0, 0);
      cyc(0, 1, 2'b01, 16'h8000, 26'h0, 0); lit("br_neg", 32'hFFFE_0004, 1, 1, 0);
      cyc(0, 1, 2'b01, 16'h7FFD, 26'h0, 0); lit("top_word", 32'hFFFF_FFFC, 1, 1, 0);
      check("top_PC4", PC4, 32'h0);
      cyc(0, 1, 2'b00, 16'h0, 26'h0, 0); lit("wrap", 32'h0, 1, 1, 0);
      cyc(0, 1, 2'b01, 16'h8000, 26'h0, 0);
      cyc(0, 1, 2'b10, 16'h0, 26'h3, 0); lit("jump_hi", 32'hF000_000C, 1, 1, 0);
`endif
      cyc(0, 1, 2'b00, 16'h0, 26'h0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
